// File: rtl/pingala_pkg.sv
// Shared definitions for the Pingala rank/unrank datapath: defaults, FSM states and
// the binomial helper used to fill the Meru Prastara coefficient table.
package pingala_pkg;

  localparam int unsigned MAX_N_DEF      = 16;
  localparam int unsigned DATA_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Multiplicative form stays exact because each partial product is itself a binomial.
  function automatic longint unsigned binom(input int unsigned n, input int unsigned k);
    longint unsigned r;
    r = 1;
    if (k > n) return 0;
    for (int unsigned i = 0; i < k; i++) begin
      r = r * longint'(n - i) / longint'(i + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/meru_coeff_lut.sv
// Combinational Meru Prastara lookup: coeff = C(a,b), zero for b>a or out-of-range addresses.
module meru_coeff_lut
  import pingala_pkg::*;
#(
  parameter int unsigned MAX_N      = MAX_N_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [4:0]            a,
  input  logic [4:0]            b,
  output logic [DATA_WIDTH-1:0] coeff
);

  logic [DATA_WIDTH-1:0] lut [MAX_N+1][MAX_N+1];

  for (genvar i = 0; i <= MAX_N; i++) begin : g_row
    for (genvar j = 0; j <= MAX_N; j++) begin : g_col
      assign lut[i][j] = DATA_WIDTH'(binom(i, j));
    end
  end

  always_comb begin
    coeff = '0;
    if (32'(a) <= MAX_N && 32'(b) <= MAX_N) begin
      coeff = lut[a][b];
    end
  end

endmodule

// File: rtl/meru_nashtam_decoder.sv
// Constant-weight unranking: walks bit positions MSB to LSB, one per cycle, peeling off
// C(p, krem) from the index to place each Guru (colex order).
module meru_nashtam_decoder
  import pingala_pkg::*;
#(
  parameter int unsigned MAX_N      = MAX_N_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            in_n,
  input  logic [4:0]            in_k,
  input  logic [DATA_WIDTH-1:0] in_index,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [MAX_N-1:0]      out_pattern,
  output logic                  out_err,
  output logic                  busy
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] idx_q, idx_d;
  logic [4:0]            krem_q, krem_d;
  logic [4:0]            p_q, p_d;
  logic [MAX_N-1:0]      pat_q, pat_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;

  logic [4:0]            lut_a, lut_b;
  logic [DATA_WIDTH-1:0] coeff;
  logic                  req_err;
  logic [MAX_N-1:0]      bit_mask;

  // One LUT serves both the accept-time range check and the per-bit walk.
  assign lut_a = (state_q == StRun) ? p_q    : in_n;
  assign lut_b = (state_q == StRun) ? krem_q : in_k;

  meru_coeff_lut #(
    .MAX_N      (MAX_N),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lut (
    .a     (lut_a),
    .b     (lut_b),
    .coeff (coeff)
  );

  assign req_err  = (in_k > in_n) || (32'(in_n) > MAX_N) || (in_index >= coeff);
  assign bit_mask = MAX_N'(1) << p_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    krem_d      = krem_q;
    p_d         = p_q;
    pat_d       = pat_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;
    busy_d      = busy_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready_q) begin
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          pat_d      = '0;
          if (req_err) begin
            err_d       = 1'b1;
            out_valid_d = 1'b1;
            state_d     = StDone;
          end else if (in_n == 5'd0) begin
            err_d       = 1'b0;
            out_valid_d = 1'b1;
            state_d     = StDone;
          end else begin
            err_d   = 1'b0;
            idx_d   = in_index;
            krem_d  = in_k;
            p_d     = in_n - 5'd1;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (krem_q != 5'd0 && idx_q >= coeff) begin
          pat_d  = pat_q | bit_mask;
          idx_d  = idx_q - coeff;
          krem_d = krem_q - 5'd1;
        end
        if (p_q == 5'd0) begin
          out_valid_d = 1'b1;
          state_d     = StDone;
        end else begin
          p_d = p_q - 5'd1;
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      krem_q      <= '0;
      p_q         <= '0;
      pat_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      krem_q      <= krem_d;
      p_q         <= p_d;
      pat_q       <= pat_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_pattern = pat_q;
  assign out_err     = err_q;
  assign busy        = busy_q;

  // Accept-time range check guarantees the walk consumes the whole rank exactly.
  a_walk_exhausted: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StRun && p_q == 5'd0) |-> (krem_d == 5'd0 && idx_d == '0));

endmodule

// File: tb/tb_meru_nashtam_decoder.sv
// Scoreboard bench for meru_nashtam_decoder: driver pushes model expectations, a negedge
// monitor pops and checks pattern, error flag, latency, weight, rank and colex order.
module tb_meru_nashtam_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_n;
  logic [4:0]  in_k;
  logic [31:0] in_index;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_pattern;
  logic        out_err;
  logic        busy;

  logic hold_off = 1'b0;
  logic rand_bp  = 1'b0;
  logic rnd_bit  = 1'b1;

  assign out_ready = !hold_off && (!rand_bp || rnd_bit);

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1 rnd_bit = ($urandom_range(0, 3) != 0);
  end

  meru_nashtam_decoder #(
    .MAX_N      (16),
    .DATA_WIDTH (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_n        (in_n),
    .in_k        (in_k),
    .in_index    (in_index),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pattern (out_pattern),
    .out_err     (out_err),
    .busy        (busy)
  );

  typedef struct {
    logic [15:0] pat;
    logic        err;
    int          lat;
    int          k;
    longint      idx;
    bit          inc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic longint binom(input int n, input int k);
    longint r;
    r = 1;
    if (k > n || k < 0) return 0;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  // Colex order of k-subsets equals numeric order of their bitmasks.
  function automatic logic [15:0] unrank(input int n, input int k, input longint idx);
    longint cnt;
    cnt = 0;
    for (int v = 0; v < (1 << n); v++) begin
      if ($countones(v) == k) begin
        if (cnt == idx) return 16'(v);
        cnt++;
      end
    end
    return 16'h0;
  endfunction

  function automatic longint rank_of(input logic [15:0] pat);
    longint r;
    int     i;
    r = 0;
    i = 0;
    for (int pos = 0; pos < 16; pos++) begin
      if (pat[pos]) begin
        i++;
        r += binom(pos, i);
      end
    end
    return r;
  endfunction

  // Monitor
  int          ncyc = 0;
  int          acc_cyc = 0;
  int          rise_cyc = 0;
  bit          prev_valid = 1'b0;
  logic [15:0] last_pat = 16'h0;
  exp_t        mon_e;

  always @(negedge clk) begin
    ncyc++;
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) rise_cyc = ncyc;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got pattern %0h, required no output", out_pattern);
        end else begin
          mon_e = sb.pop_front();
          check("pattern", longint'(out_pattern), longint'(mon_e.pat));
          check("err", longint'(out_err), longint'(mon_e.err));
          check("latency", longint'(rise_cyc - acc_cyc), longint'(mon_e.lat));
          if (!mon_e.err) begin
            check("popcount", longint'($countones(out_pattern)), longint'(mon_e.k));
            check("rank", rank_of(out_pattern), mon_e.idx);
            if (mon_e.inc) check("colex_increasing", longint'(out_pattern > last_pat), 1);
          end
          last_pat = out_pattern;
        end
      end
      if (in_valid && in_ready) acc_cyc = ncyc;
      prev_valid = out_valid;
    end
  end

  // Driver
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input int n, input int k, input longint idx, input logic [15:0] pat,
                         input bit err_exp, input bit inc);
    exp_t e;
    in_valid = 1'b1;
    in_n     = 5'(n);
    in_k     = 5'(k);
    in_index = 32'(idx);
    e.pat = pat;
    e.err = err_exp;
    e.lat = (err_exp || n == 0) ? 1 : n + 1;
    e.k   = k;
    e.idx = idx;
    e.inc = inc;
    sb.push_back(e);
  endtask

  task automatic wait_accept();
    int t;
    t = 0;
    while (!in_ready && t < 200) begin
      tick();
      t++;
    end
    check("accept_timeout", longint'(t >= 200), 0);
    if (t >= 200) void'(sb.pop_back());
    else tick();
    in_valid = 1'b0;
  endtask

  task automatic send(input int n, input int k, input longint idx, input logic [15:0] pat,
                      input bit err_exp, input bit inc);
    present(n, k, idx, pat, err_exp, inc);
    wait_accept();
  endtask

  task automatic model_send(input int n, input int k, input longint idx, input bit inc);
    bit          e;
    logic [15:0] p;
    e = (k > n) || (n > 16) || (idx >= binom(n, k));
    p = e ? 16'h0 : unrank(n, k, idx);
    send(n, k, idx, p, e, inc);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 2000) begin
      tick();
      t++;
    end
    check("drain_timeout", longint'(t >= 2000), 0);
    sb.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, longint'(in_ready), 1);
    check({tag, "_out_valid"}, longint'(out_valid), 0);
    check({tag, "_out_pattern"}, longint'(out_pattern), 0);
    check({tag, "_out_err"}, longint'(out_err), 0);
    check({tag, "_busy"}, longint'(busy), 0);
  endtask

  logic [15:0] pats4 [6];
  logic [15:0] held_pat;

  initial begin
    pats4 = '{16'h3, 16'h5, 16'h6, 16'h9, 16'hA, 16'hC};
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_n     = 5'd0;
    in_k     = 5'd0;
    in_index = 32'd0;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Full n=4,k=2 table in colex order
    for (int i = 0; i < 6; i++) send(4, 2, i, pats4[i], 1'b0, i > 0);
    drain();

    // Boundaries: top rank, one past, k>n, empty pattern
    send(16, 8, 12869, 16'hFF00, 1'b0, 1'b0);
    send(16, 8, 12870, 16'h0, 1'b1, 1'b0);
    send(3, 5, 0, 16'h0, 1'b1, 1'b0);
    send(0, 0, 0, 16'h0, 1'b0, 1'b0);
    send(17, 1, 0, 16'h0, 1'b1, 1'b0);
    drain();

    // Backpressure: result held while a second request waits
    hold_off = 1'b1;
    send(5, 2, 7, unrank(5, 2, 7), 1'b0, 1'b0);
    begin
      int t;
      t = 0;
      while (!out_valid && t < 100) begin
        tick();
        t++;
      end
      check("bp_valid_timeout", longint'(t >= 100), 0);
    end
    held_pat = unrank(5, 2, 7);
    present(3, 1, 1, 16'h2, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_out_valid", longint'(out_valid), 1);
      check("bp_in_ready", longint'(in_ready), 0);
      check("bp_pattern_stable", longint'(out_pattern), longint'(held_pat));
      check("bp_err_stable", longint'(out_err), 0);
    end
    hold_off = 1'b0;
    #1;
    check("bp_no_ready_before_handshake", longint'(in_ready), 0);
    tick();
    check("bp_valid_cleared", longint'(out_valid), 0);
    check("bp_ready_after_handshake", longint'(in_ready), 1);
    wait_accept();
    drain();

    // Asynchronous reset in the middle of a long walk
    send(16, 8, $urandom_range(0, 12869), 16'h0, 1'b0, 1'b0);
    repeat (5) tick();
    check("mid_run_busy", longint'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    sb.delete();
    tick();
    rst_n = 1'b1;
    tick();
    send(4, 1, 2, 16'h4, 1'b0, 1'b0);
    drain();

    // Exhaustive-rank sweep with random backpressure, gaps and illegal requests
    rand_bp = 1'b1;
    for (int n = 0; n <= 10; n++) begin
      for (int k = 0; k <= n; k++) begin
        for (longint idx = 0; idx < binom(n, k); idx++) begin
          model_send(n, k, idx, idx > 0);
          if ($urandom_range(0, 7) == 0) tick();
        end
        begin
          int rn, rk;
          rn = $urandom_range(0, 20);
          rk = $urandom_range(0, 31);
          model_send(rn, rk, binom(rn, rk) + $urandom_range(0, 3), 1'b0);
        end
      end
    end
    drain();
    rand_bp = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
